// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler that time-shares a two-digit seven-segment pair among N_SRC sources.
// The granted value is converted to tens/ones BCD by a sequential double-dabble, then held for DWELL cycles.
module seg_display_scheduler #(
  parameter int N_SRC = 4,
  parameter int W     = 5,
  parameter int DWELL = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_SRC-1:0]   i_req,
  input  logic [N_SRC*W-1:0] i_val,
  output logic [N_SRC-1:0]   o_grant,
  output logic [3:0]         o_bcd_ten,
  output logic [3:0]         o_bcd_one,
  output logic               o_valid,
  output logic               o_blank
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = W + 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  logic [1:0]    state_r;
  logic [IW-1:0] last_r;
  logic [SW-1:0] dd_r;      // {tens, ones, remaining value bits}
  logic [2:0]    step_r;
  logic [DW-1:0] dwell_r;
  logic [IW-1:0] pick_s;
  logic          any_req_s;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    wrap_idx = IW'(v % N_SRC);
  endfunction

  // One double-dabble step: correct nibbles that would overflow past 9, then shift the whole word.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] x);
    logic [3:0] ten;
    logic [3:0] one;
    ten = (x[SW-1 -: 4] >= 4'd5) ? x[SW-1 -: 4] + 4'd3 : x[SW-1 -: 4];
    one = (x[SW-5 -: 4] >= 4'd5) ? x[SW-5 -: 4] + 4'd3 : x[SW-5 -: 4];
    dd_step = {ten, one, x[W-1:0]} << 1;
  endfunction

  assign any_req_s = |i_req;

  // Round-robin pick: scan from farthest to nearest so the first requester after last_r wins.
  always_comb begin
    pick_s = last_r;
    for (int i = N_SRC; i >= 1; i--) begin
      pick_s = i_req[wrap_idx(int'(last_r) + i)] ? wrap_idx(int'(last_r) + i) : pick_s;
    end
  end

  // Scheduler FSM with registered display outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      last_r    <= IW'(N_SRC - 1);
      dd_r      <= '0;
      step_r    <= 3'd0;
      dwell_r   <= '0;
      o_grant   <= '0;
      o_bcd_ten <= 4'd0;
      o_bcd_one <= 4'd0;
      o_valid   <= 1'b0;
      o_blank   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            dd_r    <= {8'd0, i_val[int'(pick_s)*W +: W]};
            step_r  <= 3'd0;
            last_r  <= pick_s;
            o_grant <= {{(N_SRC-1){1'b0}}, 1'b1} << pick_s;
            o_blank <= 1'b0;
            state_r <= ST_CONV;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONV: begin
          if (step_r == 3'(W)) begin
            o_bcd_ten <= dd_r[SW-1 -: 4];
            o_bcd_one <= dd_r[SW-5 -: 4];
            dwell_r   <= DW'(DWELL - 1);
            o_valid   <= 1'b1;
            state_r   <= ST_SHOW;
          end else begin
            dd_r   <= dd_step(dd_r);
            step_r <= step_r + 3'd1;
          end
        end
        ST_SHOW: begin
          // Early release as soon as the served source withdraws its request.
          if ((dwell_r == '0) || !i_req[last_r]) begin
            o_valid <= 1'b0;
            o_grant <= '0;
            o_blank <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            dwell_r <= dwell_r - DW'(1);
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_grant <= '0;
          o_blank <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
